// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding reads to
// instruction memory and buffers returned words in a small FIFO for decode.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        jump_en,
   input  logic [31:0] jump_target
);

   localparam int          PW  = $clog2(DEPTH);
   localparam int          CW  = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic {
      S_FETCH   = 1'b0,
      S_DISCARD = 1'b1
   } state_t;

   state_t          r_state;
   logic            r_pending;
   logic [31:0]     r_req_addr;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_fifo_pc   [DEPTH];
   logic [31:0]     r_fifo_inst [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic            r_inst_valid;
   logic [31:0]     r_inst;
   logic [31:0]     r_inst_pc;

   logic            w_ack;
   logic            w_pop;
   logic            w_push;
   logic            w_keep;
   logic            w_launch;
   logic [31:0]     w_target;
   logic [31:0]     w_fetch_pc_next;
   logic [CW-1:0]   w_count_next;
   logic [CW-1:0]   w_base;
   logic [PW-1:0]   w_rd_next;
   logic [PW-1:0]   w_wr_next;
   state_t          w_state_next;
   logic            w_head_valid;
   logic [31:0]     w_head_inst;
   logic [31:0]     w_head_pc;

   assign imem_req   = r_pending;
   assign imem_addr  = r_req_addr;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign inst_valid = r_inst_valid;

   // Next-state computation: handshakes, redirect, launch decision and next FIFO head.
   always_comb begin
      w_ack           = r_pending & imem_ack;
      w_pop           = r_inst_valid & inst_ready;
      w_target        = jump_target & 32'hFFFF_FFFC;
      w_keep          = r_pending & ~w_ack;
      w_push          = 1'b0;
      w_count_next    = r_count;
      w_fetch_pc_next = r_fetch_pc;
      w_rd_next       = r_rd_ptr;
      w_wr_next       = r_wr_ptr;
      w_state_next    = r_state;
      w_base          = r_count - CW'(w_pop);
      if (jump_en) begin
         // A redirect empties the buffer; a same-edge ack or pop is absorbed.
         w_count_next    = {CW{1'b0}};
         w_fetch_pc_next = w_target;
         w_rd_next       = {PW{1'b0}};
         w_wr_next       = {PW{1'b0}};
         w_state_next    = w_keep ? S_DISCARD : S_FETCH;
      end else begin
         w_push          = w_ack & (r_state == S_FETCH);
         w_count_next    = r_count + CW'(w_push) - CW'(w_pop);
         w_rd_next       = w_pop  ? r_rd_ptr + PW'(1'b1) : r_rd_ptr;
         w_wr_next       = w_push ? r_wr_ptr + PW'(1'b1) : r_wr_ptr;
         w_fetch_pc_next = w_push ? r_fetch_pc + 32'd4 : r_fetch_pc;
         w_state_next    = w_keep ? r_state : S_FETCH;
      end
      w_launch     = ~w_keep & (w_count_next < CW'(DEPTH));
      w_head_valid = (w_count_next != {CW{1'b0}});
      // When the buffer drains to the incoming word, the head comes from the bus.
      if (!w_head_valid) begin
         w_head_inst = NOP;
         w_head_pc   = 32'h00000000;
      end else if ((w_base == {CW{1'b0}}) && w_push) begin
         w_head_inst = imem_rdata;
         w_head_pc   = r_req_addr;
      end else begin
         w_head_inst = r_fifo_inst[w_rd_next];
         w_head_pc   = r_fifo_pc[w_rd_next];
      end
   end

   // Control state, request port and registered decode outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_pending    <= 1'b0;
         r_req_addr   <= RESET_PC;
         r_fetch_pc   <= RESET_PC;
         r_rd_ptr     <= {PW{1'b0}};
         r_wr_ptr     <= {PW{1'b0}};
         r_count      <= {CW{1'b0}};
         r_inst_valid <= 1'b0;
         r_inst       <= NOP;
         r_inst_pc    <= 32'h00000000;
      end else begin
         r_state      <= w_state_next;
         r_pending    <= w_keep | w_launch;
         r_req_addr   <= w_launch ? w_fetch_pc_next : r_req_addr;
         r_fetch_pc   <= w_fetch_pc_next;
         r_rd_ptr     <= w_rd_next;
         r_wr_ptr     <= w_wr_next;
         r_count      <= w_count_next;
         r_inst_valid <= w_head_valid;
         r_inst       <= w_head_inst;
         r_inst_pc    <= w_head_pc;
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy count.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_req_addr;
         r_fifo_inst[r_wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h00000000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        jump_en;
   logic [31:0] jump_target;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .jump_en(jump_en), .jump_target(jump_target)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h00100093 + ((a >> 2) << 20);
   endfunction

   assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEADBEEF;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffer as a queue of {pc, word}, one outstanding request.
   logic [63:0] m_q[$];
   logic        m_req     = 1'b0;
   logic [31:0] m_addr    = RESET_PC;
   logic [31:0] m_fpc     = RESET_PC;
   logic        m_discard = 1'b0;

   task automatic model_step();
      logic acked;
      logic outstanding;
      if (rst) begin
         m_q.delete();
         m_req     = 1'b0;
         m_addr    = RESET_PC;
         m_fpc     = RESET_PC;
         m_discard = 1'b0;
      end else begin
         acked = m_req && imem_ack;
         if (jump_en) begin
            m_q.delete();
            m_fpc       = {jump_target[31:2], 2'b00};
            outstanding = m_req && !acked;
            m_discard   = outstanding;
         end else begin
            if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
            if (acked) begin
               if (m_discard) m_discard = 1'b0;
               else begin
                  m_q.push_back({m_addr, mem_word(m_addr)});
                  m_fpc = m_fpc + 32'd4;
               end
            end
            outstanding = m_req && !acked;
         end
         if (!outstanding) begin
            if (m_q.size() < DEPTH) begin
               m_req  = 1'b1;
               m_addr = m_fpc;
            end else begin
               m_req = 1'b0;
            end
         end
      end
   endtask

   logic chk_en = 1'b0;

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
         if (m_req) chk("imem_addr", imem_addr, m_addr);
         chk("inst_valid", {31'b0, inst_valid}, {31'b0, (m_q.size() > 0)});
         chk("inst", inst, (m_q.size() > 0) ? m_q[0][31:0] : NOP);
         chk("inst_pc", inst_pc, (m_q.size() > 0) ? m_q[0][63:32] : 32'h0);
      end
   end

   int wc        = 0;
   int cur_delay = 0;
   int hs_cnt    = 0;
   int vcnt      = 0;
   bit rand_mode = 1'b0;

   // One clock: drive ack, advance model at the edge, return at the falling edge.
   task automatic step();
      logic pre_req;
      pre_req = m_req;
      if (m_req) imem_ack = (wc >= cur_delay);
      else       imem_ack = rand_mode && ($urandom_range(0, 2) == 0);
      if (imem_req && imem_ack) hs_cnt++;
      @(posedge clk);
      model_step();
      if (rst) wc = 0;
      else if (pre_req && imem_ack) begin
         wc = 0;
         if (rand_mode) cur_delay = $urandom_range(0, 3);
      end else if (pre_req) wc++;
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   {31'b0, imem_req},   32'h0);
      chk({tag, "_addr"},  imem_addr,           RESET_PC);
      chk({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
      chk({tag, "_inst"},  inst,                NOP);
      chk({tag, "_pc"},    inst_pc,             32'h0);
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b1;
      jump_en = 1'b0; jump_target = 32'h0;
      @(negedge clk);
      step();
      chk_en = 1'b1;
      step();
      chk_reset_vals("reset");

      // Streaming with zero-wait memory.
      rst = 1'b0;
      step();
      chk("st0_req", {31'b0, imem_req}, 32'h1);
      chk("st0_addr", imem_addr, 32'h0);
      chk("st0_valid", {31'b0, inst_valid}, 32'h0);
      step();
      chk("st1_pc", inst_pc, 32'h0);
      chk("st1_inst", inst, 32'h00100093);
      chk("st1_addr", imem_addr, 32'h4);
      step();
      chk("st2_pc", inst_pc, 32'h4);
      chk("st2_inst", inst, 32'h00200093);
      chk("st2_addr", imem_addr, 32'h8);
      repeat (10) step();

      // Backpressure.
      rst = 1'b1; step(); rst = 1'b0;
      inst_ready = 1'b0; hs_cnt = 0;
      repeat (6) step();
      chk("bp_acks", hs_cnt, 32'd2);
      chk("bp_req", {31'b0, imem_req}, 32'h0);
      chk("bp_valid", {31'b0, inst_valid}, 32'h1);
      chk("bp_inst", inst, 32'h00100093);
      chk("bp_pc", inst_pc, 32'h0);
      inst_ready = 1'b1;
      step();
      chk("bp_rel_req", {31'b0, imem_req}, 32'h1);
      chk("bp_rel_addr", imem_addr, 32'h8);
      chk("bp_rel_pc", inst_pc, 32'h4);
      repeat (10) step();

      // Three wait states per access.
      rst = 1'b1; step(); rst = 1'b0;
      cur_delay = 3; hs_cnt = 0; vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (inst_valid) vcnt++;
      end
      chk("ws_acks", hs_cnt, 32'd9);
      chk("ws_valid_cycles", vcnt, 32'd9);

      // Jump while addr 8 is in flight.
      rst = 1'b1; step(); rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (imem_req && imem_addr == 32'h8) break;
         step();
      end
      chk("jif_setup_addr", imem_addr, 32'h8);
      jump_en = 1'b1; jump_target = 32'h00000041;
      step();
      jump_en = 1'b0;
      chk("jif_hold_req", {31'b0, imem_req}, 32'h1);
      chk("jif_hold_addr", imem_addr, 32'h8);
      for (int k = 0; k < 40; k++) begin
         if (inst_valid) break;
         step();
      end
      chk("jif_first_pc", inst_pc, 32'h40);
      chk("jif_first_inst", inst, 32'h01100093);
      repeat (6) step();

      // Jump coinciding with ack and pop.
      rst = 1'b1; step(); rst = 1'b0;
      cur_delay = 0; inst_ready = 1'b0;
      repeat (4) step();
      chk("jsc_full_req", {31'b0, imem_req}, 32'h0);
      inst_ready = 1'b1; step(); inst_ready = 1'b0;
      chk("jsc_pend_addr", imem_addr, 32'h8);
      jump_en = 1'b1; jump_target = 32'h00000100; inst_ready = 1'b1;
      step();
      jump_en = 1'b0;
      chk("jsc_valid", {31'b0, inst_valid}, 32'h0);
      chk("jsc_req", {31'b0, imem_req}, 32'h1);
      chk("jsc_addr", imem_addr, 32'h100);
      step();
      chk("jsc_first_pc", inst_pc, 32'h100);
      chk("jsc_first_inst", inst, 32'h04100093);
      repeat (6) step();

      // Reset while a word is buffered and a request is pending.
      rst = 1'b1; step(); rst = 1'b0;
      inst_ready = 1'b0; cur_delay = 3;
      repeat (5) step();
      chk("rms_setup_valid", {31'b0, inst_valid}, 32'h1);
      chk("rms_setup_req", {31'b0, imem_req}, 32'h1);
      rst = 1'b1; step();
      chk_reset_vals("rms");
      rst = 1'b0; step();
      chk("rms_refetch_req", {31'b0, imem_req}, 32'h1);
      chk("rms_refetch_addr", imem_addr, RESET_PC);

      // Randomized traffic, including redirects near the top of the address space.
      rand_mode = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         jump_en    = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0) jump_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           jump_target = $urandom;
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0; jump_en = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
